// File: rtl/jt89_stereo.sv
// SN76489-class PSG: three square-wave tones plus one LFSR noise channel, with signed per-channel taps.
// Define JT89_GG_STEREO_EN to build the Game Gear stereo pan register; otherwise left = right = full mix.
module jt89_stereo #(
    parameter int          DIV      = 16,
    parameter int          LFSR_W   = 16,
    parameter logic [15:0] LFSR_TAP = 16'h0009
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic               wr_n,
    input  logic [7:0]         din,
    input  logic               gg_wr_n,
    output logic signed [9:0]  ch0,
    output logic signed [9:0]  ch1,
    output logic signed [9:0]  ch2,
    output logic signed [9:0]  noise,
    output logic signed [11:0] left,
    output logic signed [11:0] right
);
    localparam int                PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]     PMAX = PW'(DIV - 1);
    localparam logic [LFSR_W-1:0] SEED = {1'b1, {(LFSR_W-1){1'b0}}};
    localparam logic [LFSR_W-1:0] TAPS = LFSR_TAP[LFSR_W-1:0];

    logic                r_wrPrev;
    logic [PW-1:0]       r_presc;
    logic [2:0]          r_latch;
    logic [2:0]          r_ctrl;
    logic [9:0]          r_tone [3];
    logic [9:0]          r_cnt [3];
    logic [3:0]          r_vol [4];
    logic [2:0]          r_bit;
    logic [5:0]          r_ncnt;
    logic                r_nclk;
    logic [LFSR_W-1:0]   r_lfsr;
    logic signed [9:0]   r_ch [4];
    logic signed [11:0]  r_left;
    logic signed [11:0]  r_right;

    logic                w_wr;
    logic                w_tick;
    logic                w_nRise;
    logic                w_fb;
    logic [2:0]          w_reg;
    logic [2:0]          w_bitNext;
    logic [5:0]          w_nReload;
    logic [LFSR_W-1:0]   w_lfsrShift;
    logic [3:0]          w_chBit;
    logic [7:0]          w_pan;
    logic signed [11:0]  w_leftSum;
    logic signed [11:0]  w_rightSum;

    function automatic logic signed [9:0] ampOf(input logic [3:0] v);
        case (v)
            4'd0:    return 10'sd511;
            4'd1:    return 10'sd406;
            4'd2:    return 10'sd322;
            4'd3:    return 10'sd256;
            4'd4:    return 10'sd203;
            4'd5:    return 10'sd161;
            4'd6:    return 10'sd128;
            4'd7:    return 10'sd102;
            4'd8:    return 10'sd81;
            4'd9:    return 10'sd64;
            4'd10:   return 10'sd51;
            4'd11:   return 10'sd40;
            4'd12:   return 10'sd32;
            4'd13:   return 10'sd26;
            4'd14:   return 10'sd20;
            default: return 10'sd0;
        endcase
    endfunction

    // A data byte reuses the register chosen by the last latch byte.
    assign w_wr    = ~wr_n & r_wrPrev;
    assign w_tick  = cen && (r_presc == PMAX);
    assign w_reg   = din[7] ? din[6:4] : r_latch;
    assign w_chBit = {r_lfsr[0], r_bit};

    always_comb begin
        w_bitNext = r_bit;
        for (int i = 0; i < 3; i++) begin
            if (r_tone[i] <= 10'd1)
                w_bitNext[i] = 1'b1;
            else if (r_cnt[i] == 10'd0)
                w_bitNext[i] = ~r_bit[i];
        end
    end

    // Noise clock rises either on the internal divider or on tone 2's output; LFSR steps on that rise.
    always_comb begin
        case (r_ctrl[1:0])
            2'd0:    w_nReload = 6'd15;
            2'd1:    w_nReload = 6'd31;
            default: w_nReload = 6'd63;
        endcase
        if (r_ctrl[1:0] == 2'd3)
            w_nRise = w_tick & ~r_bit[2] & w_bitNext[2];
        else
            w_nRise = w_tick & (r_ncnt == 6'd0) & ~r_nclk;
        w_fb        = r_ctrl[2] ? ^(r_lfsr & TAPS) : r_lfsr[0];
        w_lfsrShift = {w_fb, r_lfsr[LFSR_W-1:1]};
        if (w_lfsrShift == '0)
            w_lfsrShift = SEED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_bit   <= 3'b111;
            r_ncnt  <= 6'd0;
            r_nclk  <= 1'b0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= 10'd0;
        end else begin
            if (cen)
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
            if (w_tick) begin
                r_bit <= w_bitNext;
                for (int i = 0; i < 3; i++)
                    r_cnt[i] <= (r_cnt[i] == 10'd0) ? r_tone[i] - 10'd1 : r_cnt[i] - 10'd1;
                if (r_ncnt == 6'd0) begin
                    r_ncnt <= w_nReload;
                    r_nclk <= ~r_nclk;
                end else begin
                    r_ncnt <= r_ncnt - 6'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPrev <= 1'b1;
            r_latch  <= 3'd0;
            r_ctrl   <= 3'd0;
            r_lfsr   <= SEED;
            for (int i = 0; i < 3; i++) r_tone[i] <= 10'd0;
            for (int i = 0; i < 4; i++) r_vol[i] <= 4'hF;
        end else begin
            r_wrPrev <= wr_n;
            if (w_wr) begin
                if (din[7])
                    r_latch <= din[6:4];
                case (w_reg)
                    3'd0, 3'd2, 3'd4: begin
                        if (din[7]) r_tone[w_reg[2:1]][3:0] <= din[3:0];
                        else        r_tone[w_reg[2:1]][9:4] <= din[5:0];
                    end
                    3'd6:    r_ctrl <= din[2:0];
                    default: r_vol[w_reg[2:1]] <= din[3:0];
                endcase
            end
            // A noise-control write reseeds and wins over a shift in the same cycle.
            if (w_wr && (w_reg == 3'd6))
                r_lfsr <= SEED;
            else if (w_nRise)
                r_lfsr <= w_lfsrShift;
        end
    end

`ifdef JT89_GG_STEREO_EN
    logic       r_ggPrev;
    logic [7:0] r_stereo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ggPrev <= 1'b1;
            r_stereo <= 8'hFF;
        end else begin
            r_ggPrev <= gg_wr_n;
            if (~gg_wr_n & r_ggPrev)
                r_stereo <= din;
        end
    end
    assign w_pan = r_stereo;
`else
    logic w_unusedGg;
    assign w_unusedGg = gg_wr_n;
    assign w_pan      = 8'hFF;
`endif

    always_comb begin
        w_leftSum  = '0;
        w_rightSum = '0;
        for (int i = 0; i < 4; i++) begin
            if (w_pan[i+4]) w_leftSum  = w_leftSum  + {{2{r_ch[i][9]}}, r_ch[i]};
            if (w_pan[i])   w_rightSum = w_rightSum + {{2{r_ch[i][9]}}, r_ch[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_ch[i] <= 10'sd0;
            r_left  <= 12'sd0;
            r_right <= 12'sd0;
        end else begin
            for (int i = 0; i < 4; i++)
                r_ch[i] <= w_chBit[i] ? ampOf(r_vol[i]) : -ampOf(r_vol[i]);
            r_left  <= w_leftSum;
            r_right <= w_rightSum;
        end
    end

    assign ch0   = r_ch[0];
    assign ch1   = r_ch[1];
    assign ch2   = r_ch[2];
    assign noise = r_ch[3];
    assign left  = r_left;
    assign right = r_right;
endmodule
